// File: rtl/button_press_detector.sv
// Button front end: two-flop synchronizer and counter debounce, followed by an
// IDLE/HELD/REPEAT FSM that issues press, hold, repeat and release pulses.
module button_press_detector #(
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned REPEAT_CYCLES = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pressed,
  output logic press_pulse,
  output logic hold_pulse,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic long_release
);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic             long_flag;
  state_t           state;

  logic deb_done;
  logic rise;
  logic fall;

  // A flip happens on the edge where the mismatch counter saturates.
  always_comb begin
    deb_done = (s2 != pressed) && (deb_cnt == DEB_LAST);
    rise     = deb_done && s2;
    fall     = deb_done && !s2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      pressed <= 1'b0;
      deb_cnt <= '0;
    end else begin
      s1 <= in;
      s2 <= s1;
      if (s2 == pressed) begin
        deb_cnt <= '0;
      end else if (deb_done) begin
        pressed <= s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CNT_ONE;
      end
    end
  end

  // A falling flip overrides any hold/repeat expiry on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      long_flag     <= 1'b0;
      press_pulse   <= 1'b0;
      hold_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      long_release  <= 1'b0;
    end else begin
      press_pulse   <= rise;
      release_pulse <= fall;
      long_release  <= fall && long_flag;
      hold_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      if (fall) begin
        state     <= IDLE;
        hold_cnt  <= '0;
        rep_cnt   <= '0;
        long_flag <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state    <= HELD;
              hold_cnt <= '0;
            end
          end
          HELD: begin
            if (hold_cnt == HOLD_LAST) begin
              hold_pulse <= 1'b1;
              state      <= REPEAT;
              rep_cnt    <= '0;
              long_flag  <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + CNT_ONE;
            end
          end
          REPEAT: begin
            if (rep_cnt == REP_LAST) begin
              repeat_pulse <= 1'b1;
              rep_cnt      <= '0;
            end else begin
              rep_cnt <= rep_cnt + CNT_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_press_detector.sv
// Bench for button_press_detector: directed scenarios plus random button
// activity, checked every cycle against a timestamp-based reference model.
module tb_button_press_detector;

  localparam int DEB  = 4;
  localparam int HOLD = 16;
  localparam int REP  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in  = 1'b0;
  logic pressed, press_pulse, hold_pulse, repeat_pulse, release_pulse, long_release;

  button_press_detector #(
    .DEB_CYCLES   (DEB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .CNT_W        (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .hold_pulse   (hold_pulse),
    .repeat_pulse (repeat_pulse),
    .release_pulse(release_pulse),
    .long_release (long_release)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_no = 0;
  int base = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edge_no, got, exp);
    end
  endtask

  // Reference model: input delay line, run-length debounce, and pulse
  // times derived from the edge at which the press was recognised.
  logic q0, q1, m_pressed;
  int   m_run, m_t, t_p;
  logic e_press, e_hold, e_rep, e_rel, e_long;

  task automatic model_reset();
    q0 = 0; q1 = 0; m_pressed = 0; m_run = 0; m_t = 0; t_p = 0;
    e_press = 0; e_hold = 0; e_rep = 0; e_rel = 0; e_long = 0;
  endtask

  task automatic model_edge();
    logic seen;
    int d;
    if (rst) begin
      model_reset();
      return;
    end
    m_t++;
    seen = q0; q0 = q1; q1 = in;
    e_press = 0; e_hold = 0; e_rep = 0; e_rel = 0; e_long = 0;
    if (seen != m_pressed) begin
      m_run++;
      if (m_run == DEB) begin
        m_run = 0;
        m_pressed = seen;
        if (seen) begin
          e_press = 1;
          t_p = m_t;
        end else begin
          e_rel  = 1;
          e_long = (m_t - t_p) > HOLD;
        end
      end
    end else begin
      m_run = 0;
    end
    if (m_pressed && !e_press) begin
      d = m_t - t_p;
      e_hold = (d == HOLD);
      e_rep  = (d > HOLD) && ((d - HOLD) % REP == 0);
    end
  endtask

  task automatic check_outputs();
    check("pressed", pressed, m_pressed);
    check("press_pulse", press_pulse, e_press);
    check("hold_pulse", hold_pulse, e_hold);
    check("repeat_pulse", repeat_pulse, e_rep);
    check("release_pulse", release_pulse, e_rel);
    check("long_release", long_release, e_long);
  endtask

  // Per-scenario observations, indexed from the scenario's first edge.
  int n_press, n_hold, n_rep, n_rel;
  int press_at, hold_at, rep_at, rel_at, rel_long;

  task automatic scen_start();
    base = edge_no;
    n_press = 0; n_hold = 0; n_rep = 0; n_rel = 0;
    press_at = -1; hold_at = -1; rep_at = -1; rel_at = -1; rel_long = -1;
  endtask

  task automatic step(input logic v);
    int idx;
    in = v;
    @(posedge clk);
    idx = edge_no - base;
    edge_no++;
    model_edge();
    #1;
    check_outputs();
    if (press_pulse) begin n_press++; press_at = idx; end
    if (hold_pulse) begin n_hold++; hold_at = idx; end
    if (repeat_pulse) begin n_rep++; if (rep_at < 0) rep_at = idx; end
    if (release_pulse) begin n_rel++; rel_at = idx; rel_long = int'(long_release); end
  endtask

  task automatic steps(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic async_reset(input logic v, input int n);
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    steps(v, n);
    rst = 1'b0;
  endtask

  initial begin
    logic lvl;
    int len;
    model_reset();
    #1;
    check_outputs();
    steps(1'b0, 3);
    rst = 1'b0;
    steps(1'b0, 6);

    scen_start();
    steps(1'b1, 10);
    steps(1'b0, 20);
    check("clean_press_at", press_at, 5);
    check("clean_release_at", rel_at, 15);
    check("clean_long", rel_long, 0);
    check("clean_holds", n_hold, 0);

    scen_start();
    steps(1'b1, 3);
    steps(1'b0, 15);
    check("glitch3_presses", n_press, 0);
    check("glitch3_releases", n_rel, 0);

    scen_start();
    steps(1'b1, 4);
    steps(1'b0, 15);
    check("glitch4_presses", n_press, 1);
    check("glitch4_press_at", press_at, 5);

    scen_start();
    steps(1'b1, 50);
    steps(1'b0, 20);
    check("long_press_at", press_at, 5);
    check("long_hold_at", hold_at, 21);
    check("long_first_rep", rep_at, 29);
    check("long_reps", n_rep, 4);
    check("long_release_at", rel_at, 55);
    check("long_long", rel_long, 1);

    scen_start();
    steps(1'b1, 16);
    steps(1'b0, 15);
    check("boundary_holds", n_hold, 0);
    check("boundary_release_at", rel_at, 21);
    check("boundary_long", rel_long, 0);

    scen_start();
    steps(1'b1, 30);
    for (int i = 0; i < 10; i++) step(((i / 2) % 2) == 1);
    steps(1'b0, 20);
    check("bounce_presses", n_press, 1);
    check("bounce_releases", n_rel, 1);
    check("bounce_release_at", rel_at, 43);
    check("bounce_long", rel_long, 1);

    scen_start();
    steps(1'b1, 26);
    async_reset(1'b1, 4);
    steps(1'b1, 10);
    check("rst_presses", n_press, 2);
    check("rst_press_at", press_at, 35);
    check("rst_releases", n_rel, 0);
    steps(1'b0, 20);

    lvl = 1'b0;
    for (int b = 0; b < 80; b++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 45);
      steps(lvl, len);
      if ($urandom_range(0, 19) == 0) async_reset(lvl, 2);
    end
    steps(1'b0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
